// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: FSM state encoding, the
// word-alignment mask and the address error check used on every access.
// Ports: none (package only).
package mem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    // Low address bits that must be zero for a word access.
    localparam logic [63:0] ALIGN_MASK = 64'h3;

    // Width of the wait-state counter (WAIT_CYCLES is limited to 0..15).
    localparam int unsigned WAIT_CNT_W = 4;

    // An access is bad when it is not word aligned, or when any address bit
    // above the word index is set (the array is not aliased/mirrored).
    // The address is passed zero-extended to 64 bits so one helper serves
    // any WIDTH up to 64.
    function automatic logic addr_is_bad(input logic [63:0] addr,
                                         input int unsigned idx_w);
        logic [63:0] above_mask;
        above_mask = ~((64'd1 << (idx_w + 2)) - 64'd1);
        return ((addr & ALIGN_MASK) != 64'd0) || ((addr & above_mask) != 64'd0);
    endfunction

endpackage

// File: rtl/mem_responder_array.sv
// Single-port synchronous RAM, WIDTH x DEPTH, write-first not needed because
// read and write never target the same edge. Latency: read data one edge after
// i_re. No backpressure. Contents are never reset.
// Ports: clk, i_we/i_re strobes, i_addr word index, i_wdata, o_rdata.
module mem_array #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic             i_re,
    input  logic [AW-1:0]    i_addr,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        // Read register holds its value between reads; the responder only
        // looks at it during the single RESP cycle that follows a read.
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the multicycle core's unified memory port.
// Latency: request accepted at edge 0, resp_valid high in cycle WAIT_CYCLES+1.
// Backpressure: req_ready low while busy (requests ignored, not queued);
// responses are one-cycle pulses with no acknowledge.
// Ports: clk, rst (sync, active high); req_valid/req_write/req_addr/req_wdata
// in, req_ready out; resp_valid/resp_rdata/resp_err out.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic             req_write,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             req_ready,
    output logic             resp_valid,
    output logic [WIDTH-1:0] resp_rdata,
    output logic             resp_err
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
        (WAIT_CYCLES > 0) ? WAIT_CNT_W'(WAIT_CYCLES - 1) : '0;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [WAIT_CNT_W-1:0] r_cnt;
    logic [WAIT_CNT_W-1:0] w_cnt_nxt;

    logic                  r_write;
    logic [WIDTH-1:0]      r_addr;
    logic [WIDTH-1:0]      r_wdata;
    logic                  r_resp_err;
    logic                  r_resp_rd;

    logic                  w_accept;
    logic                  w_enter_resp;
    logic                  w_acc_write;
    logic [WIDTH-1:0]      w_acc_addr;
    logic [WIDTH-1:0]      w_acc_wdata;
    logic                  w_err;
    logic                  w_mem_we;
    logic                  w_mem_re;
    logic [WIDTH-1:0]      w_mem_rdata;

    // ------------------------------------------------------------------
    // FSM: state and wait counter registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state, counter and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        w_accept     = 1'b0;
        w_enter_resp = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_accept = 1'b1;
                    if (WAIT_CYCLES > 0) begin
                        w_state_nxt = ST_WAIT;
                        w_cnt_nxt   = WAIT_LOAD;
                    end else begin
                        // No wait states: the access happens on the accept edge.
                        w_state_nxt  = ST_RESP;
                        w_enter_resp = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt  = ST_RESP;
                    w_enter_resp = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ST_RESP: begin
                resp_valid  = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request latch. Datapath registers need no reset: they are only
    // consumed after a fresh accept.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_write <= req_write;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
        end
    end

    // With zero wait states the access edge is the accept edge, so the
    // request must come straight from the port rather than the latch.
    assign w_acc_write = (r_state == ST_IDLE) ? req_write : r_write;
    assign w_acc_addr  = (r_state == ST_IDLE) ? req_addr  : r_addr;
    assign w_acc_wdata = (r_state == ST_IDLE) ? req_wdata : r_wdata;

    assign w_err = addr_is_bad(64'(w_acc_addr), IDX_W);

    // Reset on the would-be access edge aborts the request, so it also
    // blocks the array write.
    assign w_mem_we = w_enter_resp & ~rst & ~w_err &  w_acc_write;
    assign w_mem_re = w_enter_resp & ~rst & ~w_err & ~w_acc_write;

    mem_array #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem_array (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_re    (w_mem_re),
        .i_addr  (w_acc_addr[IDX_W+1:2]),
        .i_wdata (w_acc_wdata),
        .o_rdata (w_mem_rdata)
    );

    // Response qualifiers captured on the access edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_resp_err <= 1'b0;
            r_resp_rd  <= 1'b0;
        end else if (w_enter_resp) begin
            r_resp_err <= w_err;
            r_resp_rd  <= w_mem_re;
        end
    end

    // Data and error are forced to zero outside the response pulse.
    assign resp_err   = resp_valid & r_resp_err;
    assign resp_rdata = (resp_valid & r_resp_rd) ? w_mem_rdata : '0;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        vld [2];
    logic        wr  [2];
    logic [31:0] ad  [2];
    logic [31:0] wd  [2];
    logic        rdy [2];
    logic        rv  [2];
    logic [31:0] rd  [2];
    logic        re  [2];

    mem_responder #(.WIDTH(32), .DEPTH(64), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(vld[0]), .req_write(wr[0]), .req_addr(ad[0]), .req_wdata(wd[0]),
        .req_ready(rdy[0]), .resp_valid(rv[0]), .resp_rdata(rd[0]), .resp_err(re[0])
    );

    mem_responder #(.WIDTH(32), .DEPTH(64), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(vld[1]), .req_write(wr[1]), .req_addr(ad[1]), .req_wdata(wd[1]),
        .req_ready(rdy[1]), .resp_valid(rv[1]), .resp_rdata(rd[1]), .resp_err(re[1])
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // ------------------------------------------------------------------
    // Reference model: per instance, a count of cycles left until the
    // block is free again. The response is due in the last busy cycle,
    // the access takes effect on the edge entering that cycle.
    // ------------------------------------------------------------------
    int          wait_c [2] = '{2, 0};
    int          busy   [2] = '{0, 0};
    logic        m_wr   [2];
    logic [31:0] m_ad   [2];
    logic [31:0] m_wd   [2];
    logic [31:0] exp_rd [2];
    logic        exp_er [2];
    logic [31:0] mm     [2][64];
    int          cyc     = 0;
    bit          started = 0;

    task automatic m_access(input int k);
        bit bad;
        bad = (m_ad[k] % 4 != 0) || (m_ad[k] >= 32'd256);
        exp_er[k] = bad;
        exp_rd[k] = 32'h0;
        if (!bad) begin
            if (m_wr[k]) mm[k][m_ad[k] / 4] = m_wd[k];
            else         exp_rd[k] = mm[k][m_ad[k] / 4];
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (rst) started = 1;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                busy[k] = 0;
            end else if (busy[k] > 0) begin
                if (busy[k] == 2) m_access(k);
                busy[k]--;
            end else if (vld[k]) begin
                m_wr[k] = wr[k];
                m_ad[k] = ad[k];
                m_wd[k] = wd[k];
                busy[k] = wait_c[k] + 1;
                if (busy[k] == 1) m_access(k);
            end
        end
    end

    // Compare process: every cycle once reset has been seen.
    always @(negedge clk) begin
        if (started) begin
            for (int k = 0; k < 2; k++) begin
                logic ev;
                ev = (busy[k] == 1);
                check($sformatf("req_ready[%0d]", k), 32'(rdy[k]), 32'(busy[k] == 0));
                check($sformatf("resp_valid[%0d]", k), 32'(rv[k]), 32'(ev));
                check($sformatf("resp_err[%0d]", k), 32'(re[k]), ev ? 32'(exp_er[k]) : 32'h0);
                check($sformatf("resp_rdata[%0d]", k), rd[k], ev ? exp_rd[k] : 32'h0);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic req(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] ord, output logic oer, output int lat);
        int n;
        ord = 32'h0; oer = 1'b0; lat = -1;
        @(negedge clk);
        vld[k] = 1'b1; wr[k] = w; ad[k] = a; wd[k] = d;
        n = 0;
        while (!rdy[k] && n < 50) begin @(negedge clk); n++; end
        if (!rdy[k]) begin
            timeout("accept");
            vld[k] = 1'b0;
            return;
        end
        @(negedge clk);
        vld[k] = 1'b0;
        lat = 1;
        while (!rv[k] && lat < 50) begin @(negedge clk); lat++; end
        if (!rv[k]) begin
            timeout("response");
            lat = -1;
            return;
        end
        ord = rd[k];
        oer = re[k];
    endtask

    // Hold req_valid high with incrementing load addresses; accepts must be
    // spaced by the full turnaround.
    task automatic stream(input int k, input int gap);
        int  acc[$];
        int  n;
        bit  inc;
        vld[k] = 1'b1; wr[k] = 1'b0; ad[k] = 32'h0;
        n = 0; inc = 0;
        while (acc.size() < 3 && n < 40) begin
            if (inc) ad[k] += 32'd4;
            inc = 0;
            if (rdy[k]) begin acc.push_back(cyc + 1); inc = 1; end
            @(negedge clk);
            n++;
        end
        vld[k] = 1'b0;
        check($sformatf("stream%0d_accepts", k), 32'(acc.size()), 32'd3);
        if (acc.size() == 3) begin
            check($sformatf("stream%0d_gap1", k), 32'(acc[1] - acc[0]), 32'(gap));
            check($sformatf("stream%0d_gap2", k), 32'(acc[2] - acc[1]), 32'(gap));
        end
        repeat (gap + 1) @(negedge clk);
    endtask

    logic [31:0] g_rd;
    logic        g_er;
    int          g_lat;
    int          seen;

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            vld[k] = 1'b0; wr[k] = 1'b0; ad[k] = 32'h0; wd[k] = 32'h0;
        end
        repeat (3) @(negedge clk);
        check("reset_ready", 32'(rdy[0]), 32'd1);
        check("reset_valid", 32'(rv[0]), 32'd0);
        check("reset_rdata", rd[0], 32'h0);
        check("reset_err", 32'(re[0]), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_ready", 32'(rdy[0]), 32'd1);
        check("post_reset_ready_w0", 32'(rdy[1]), 32'd1);

        // Fill both arrays with known patterns.
        for (int i = 0; i < 64; i++) begin
            req(0, 1'b1, 32'(i * 4), 32'hA500_0000 | 32'(i), g_rd, g_er, g_lat);
            req(1, 1'b1, 32'(i * 4), 32'h5A00_0000 | 32'(i), g_rd, g_er, g_lat);
        end

        // Store then load, WAIT_CYCLES=2.
        req(0, 1'b1, 32'h10, 32'hDEAD_BEEF, g_rd, g_er, g_lat);
        check("store_latency", 32'(g_lat), 32'd3);
        check("store_err", 32'(g_er), 32'd0);
        check("store_rdata", g_rd, 32'h0);
        req(0, 1'b0, 32'h10, 32'h0, g_rd, g_er, g_lat);
        check("load_latency", 32'(g_lat), 32'd3);
        check("load_rdata", g_rd, 32'hDEAD_BEEF);

        // Misaligned and out-of-range accesses.
        req(0, 1'b0, 32'h12, 32'h0, g_rd, g_er, g_lat);
        check("misalign_err", 32'(g_er), 32'd1);
        check("misalign_rdata", g_rd, 32'h0);
        req(0, 1'b1, 32'h100, 32'h1111_1111, g_rd, g_er, g_lat);
        check("range_err", 32'(g_er), 32'd1);
        req(0, 1'b0, 32'h0, 32'h0, g_rd, g_er, g_lat);
        check("range_no_alias", g_rd, 32'hA500_0000);

        @(negedge clk);
        stream(0, 4);

        // Reset during WAIT aborts a store.
        vld[0] = 1'b1; wr[0] = 1'b1; ad[0] = 32'h20; wd[0] = 32'h1234_5678;
        seen = 0;
        while (!rdy[0] && seen < 20) begin @(negedge clk); seen++; end
        @(negedge clk);
        vld[0] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (rv[0]) seen++;
            @(negedge clk);
        end
        check("abort_no_resp", 32'(seen), 32'd0);
        req(0, 1'b0, 32'h20, 32'h0, g_rd, g_er, g_lat);
        check("abort_prior_data", g_rd, 32'hA500_0008);

        // Zero wait states.
        req(1, 1'b0, 32'h4, 32'h0, g_rd, g_er, g_lat);
        check("w0_latency", 32'(g_lat), 32'd1);
        check("w0_rdata", g_rd, 32'h5A00_0001);
        @(negedge clk);
        stream(1, 2);

        // Randomized traffic on both instances, occasional resets.
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < 2; k++) begin
                int r;
                vld[k] = ($urandom_range(0, 2) != 0);
                wr[k]  = 1'($urandom_range(0, 1));
                ad[k]  = 32'($urandom_range(0, 63)) * 32'd4;
                r = $urandom_range(0, 9);
                if (r == 0) ad[k] = ad[k] | 32'($urandom_range(1, 3));
                if (r == 1) ad[k] = ad[k] | (32'h100 << $urandom_range(0, 23));
                wd[k] = $urandom;
            end
            rst = ($urandom_range(0, 99) == 0);
            @(negedge clk);
        end
        for (int k = 0; k < 2; k++) vld[k] = 1'b0;
        rst = 1'b0;
        repeat (6) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
